// File: rtl/pifo_egress_pkg.sv
// Shared types and helpers for the PIFO egress collector.
// The optional statistics build is selected with the PIFO_EGRESS_STATS_EN macro.
package pifo_egress_pkg;

    localparam int DEF_PTW           = 16;
    localparam int DEF_MTW           = 0;
    localparam int DEF_TREE_NUM_BITS = 2;
    localparam int CNT_W             = 32;
    localparam int MAX_DW            = 256;

    typedef struct packed {
        logic [DEF_TREE_NUM_BITS-1:0]   tree_id;
        logic [DEF_MTW+DEF_PTW-1:0]     data;
    } egress_entry_t;

    // The tree reports "nothing to pop" by returning an all-ones word of the live width.
    function automatic logic is_empty_marker(input logic [MAX_DW-1:0] data, input int width);
        logic all_ones;
        all_ones = 1'b1;
        for (int i = 0; i < MAX_DW; i++) begin
            if (i < width && !data[i]) all_ones = 1'b0;
        end
        return all_ones;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
        logic [CNT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/pifo_egress_ring.sv
// Flop-based ring buffer: up to LEVEL compacted writes per cycle, one read per cycle.
module pifo_egress_ring #(
    parameter int W     = 18,
    parameter int LEVEL = 4,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1,
    localparam int NW   = $clog2(LEVEL) + 1
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic [NW-1:0]             wr_num,
    input  logic [LEVEL-1:0][W-1:0]   wr_data,
    input  logic                      rd,
    output logic [W-1:0]              head,
    output logic [CW-1:0]             count,
    output logic [CW-1:0]             count_next
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign count_next = count + CW'(wr_num) - CW'(rd);
    assign head       = mem[rd_ptr];

    // NOTE: storage has no reset; stale entries are never visible because count gates validity.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LEVEL; k++) begin
            if (NW'(k) < wr_num) mem[wr_ptr + AW'(k)] <= wr_data[k];
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(wr_num);
            rd_ptr <= rd_ptr + AW'(rd);
            count  <= count_next;
        end
    end

endmodule

// File: rtl/pifo_egress_collector.sv
// Collects per-lane PIFO pop results into a shared ring and drains them to one egress port.
// Define PIFO_EGRESS_STATS_EN to add saturating empty-pop, drop and egress counters.
module pifo_egress_collector
    import pifo_egress_pkg::*;
#(
    parameter int PTW            = 16,
    parameter int MTW            = 0,
    parameter int LEVEL          = 4,
    parameter int TREE_NUM       = 4,
    parameter int DEPTH          = 16,
    parameter int RSV            = 2 * LEVEL,
    localparam int TREE_NUM_BITS = $clog2(TREE_NUM),
    localparam int DW            = MTW + PTW,
    localparam int CW            = $clog2(DEPTH) + 1
) (
    input  logic                                  i_clk,
    input  logic                                  i_arst,
    input  logic [LEVEL-1:0]                      i_is_level0_pop,
    input  logic [LEVEL-1:0][TREE_NUM_BITS-1:0]   i_tree_id,
    input  logic [LEVEL-1:0][DW-1:0]              i_pop_data,
    output logic [LEVEL-1:0]                      o_pop_allow,
    output logic                                  o_valid,
    input  logic                                  i_ready,
    output logic [TREE_NUM_BITS-1:0]              o_tree_id,
    output logic [DW-1:0]                         o_data,
    output logic [CW-1:0]                         o_count,
    output logic                                  o_overflow
`ifdef PIFO_EGRESS_STATS_EN
    ,
    output logic [CNT_W-1:0]                      o_empty_pop_cnt,
    output logic [CNT_W-1:0]                      o_drop_cnt,
    output logic [CNT_W-1:0]                      o_egress_cnt
`endif
);

    localparam int EW  = TREE_NUM_BITS + DW;
    localparam int NW  = $clog2(LEVEL) + 1;
    localparam int RRW = (LEVEL > 1) ? $clog2(LEVEL) : 1;

    logic [RRW-1:0]            rr, rr_next, lane, last;
    logic [NW-1:0]             gcnt, drop_num;
    logic [LEVEL-1:0][EW-1:0]  wr_data;
    logic [CW-1:0]             count, count_next, free;
    logic [EW-1:0]             head;
    logic                      xfer;
`ifdef PIFO_EGRESS_STATS_EN
    logic [NW-1:0]             empty_num;
`endif

    assign free = CW'(DEPTH) - count;

    // Walk lanes in rr order; valid results are packed into consecutive slots until space runs out.
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    always_comb begin
        wr_data  = '0;
        gcnt     = '0;
        drop_num = '0;
        last     = rr;
        rr_next  = rr;
        lane     = '0;
`ifdef PIFO_EGRESS_STATS_EN
        empty_num = '0;
`endif
        for (int k = 0; k < LEVEL; k++) begin
            lane = RRW'((int'(rr) + k) % LEVEL);
            if (i_is_level0_pop[lane]) begin
                if (!is_empty_marker(MAX_DW'(i_pop_data[lane]), DW)) begin
                    if (CW'(gcnt) < free) begin
                        wr_data[RRW'(gcnt)] = {i_tree_id[lane], i_pop_data[lane]};
                        gcnt = gcnt + NW'(1);
                        last = lane;
                    end else begin
                        drop_num = drop_num + NW'(1);
                    end
                end
`ifdef PIFO_EGRESS_STATS_EN
                else begin
                    empty_num = empty_num + NW'(1);
                end
`endif
            end
        end
        if (gcnt != '0) rr_next = (int'(last) == LEVEL - 1) ? '0 : last + RRW'(1);
    end

    pifo_egress_ring #(
        .W     (EW),
        .LEVEL (LEVEL),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk        (i_clk),
        .arst       (i_arst),
        .wr_num     (gcnt),
        .wr_data    (wr_data),
        .rd         (xfer),
        .head       (head),
        .count      (count),
        .count_next (count_next)
    );

    assign o_valid                = (count != '0);
    assign xfer                   = o_valid && i_ready;
    assign {o_tree_id, o_data}    = o_valid ? head : '0;
    assign o_count                = count;

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            rr          <= '0;
            o_overflow  <= 1'b0;
            o_pop_allow <= '1;
        end else begin
            rr          <= rr_next;
            o_overflow  <= o_overflow || (drop_num != '0);
            o_pop_allow <= {LEVEL{(CW'(DEPTH) - count_next) > CW'(RSV)}};
        end
    end

`ifdef PIFO_EGRESS_STATS_EN
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            o_empty_pop_cnt <= '0;
            o_drop_cnt      <= '0;
            o_egress_cnt    <= '0;
        end else begin
            o_empty_pop_cnt <= sat_add(o_empty_pop_cnt, CNT_W'(empty_num));
            o_drop_cnt      <= sat_add(o_drop_cnt, CNT_W'(drop_num));
            o_egress_cnt    <= sat_add(o_egress_cnt, CNT_W'(xfer));
        end
    end
`endif

endmodule

// File: tb/tb_pifo_egress_collector.sv
// Directed, table-driven bench for pifo_egress_collector with default parameters.
module tb_pifo_egress_collector;
    import pifo_egress_pkg::*;

    logic             i_clk = 1'b0;
    logic             i_arst;
    logic [3:0]       i_is_level0_pop;
    logic [3:0][1:0]  i_tree_id;
    logic [3:0][15:0] i_pop_data;
    logic             i_ready;
    logic [3:0]       o_pop_allow;
    logic             o_valid;
    logic [1:0]       o_tree_id;
    logic [15:0]      o_data;
    logic [4:0]       o_count;
    logic             o_overflow;
`ifdef PIFO_EGRESS_STATS_EN
    logic [31:0]      o_empty_pop_cnt, o_drop_cnt, o_egress_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    pifo_egress_collector #(
        .PTW(16), .MTW(0), .LEVEL(4), .TREE_NUM(4), .DEPTH(16), .RSV(8)
    ) dut (
        .i_clk           (i_clk),
        .i_arst          (i_arst),
        .i_is_level0_pop (i_is_level0_pop),
        .i_tree_id       (i_tree_id),
        .i_pop_data      (i_pop_data),
        .o_pop_allow     (o_pop_allow),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_tree_id       (o_tree_id),
        .o_data          (o_data),
        .o_count         (o_count),
        .o_overflow      (o_overflow)
`ifdef PIFO_EGRESS_STATS_EN
        ,
        .o_empty_pop_cnt (o_empty_pop_cnt),
        .o_drop_cnt      (o_drop_cnt),
        .o_egress_cnt    (o_egress_cnt)
`endif
    );

    typedef struct {
        logic [3:0]    pop;
        logic [7:0]    tids;
        logic [63:0]   data;
        logic          ready;
        logic          ev;
        egress_entry_t eh;
        logic [4:0]    ec;
        logic          eo;
        logic [3:0]    ea;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] pop, input logic [7:0] tids, input logic [63:0] data,
                       input logic ready, input logic ev, input logic [1:0] et, input logic [15:0] ed,
                       input logic [4:0] ec, input logic eo, input logic [3:0] ea);
        vec_t v;
        v.pop = pop; v.tids = tids; v.data = data; v.ready = ready;
        v.ev = ev; v.eh = {et, ed}; v.ec = ec; v.eo = eo; v.ea = ea;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic ev, input logic [1:0] et,
                                 input logic [15:0] ed, input logic [4:0] ec, input logic eo,
                                 input logic [3:0] ea);
        check({tag, " valid"}, 32'(o_valid), 32'(ev));
        check({tag, " tree"}, 32'(o_tree_id), 32'(et));
        check({tag, " data"}, 32'(o_data), 32'(ed));
        check({tag, " count"}, 32'(o_count), 32'(ec));
        check({tag, " overflow"}, 32'(o_overflow), 32'(eo));
        check({tag, " allow"}, 32'(o_pop_allow), 32'(ea));
    endtask

    logic [15:0] drain_d [8] = '{16'h35, 16'h36, 16'h37, 16'h38, 16'h39, 16'h3A, 16'h3B, 16'h3C};
    logic [1:0]  drain_t [8] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        // rotation and ordering from rr=0
        add(4'b1111, 8'hE4, 64'h0013_0012_0011_0010, 0, 1, 0, 16'h10,  4, 0, 4'hF);
        add(4'b1010, 8'h48, 64'h0023_DEAD_0021_DEAD, 0, 1, 0, 16'h10,  6, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 1, 16'h11,  5, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 2, 16'h12,  4, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 3, 16'h13,  3, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 2, 16'h21,  2, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 1, 16'h23,  1, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 0, 0, 16'h00,  0, 0, 4'hF);
        // single capture, then drain
        add(4'b0100, 8'h10, 64'h0000_0042_0000_0000, 0, 1, 1, 16'h42,  1, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 0, 0, 16'h00,  0, 0, 4'hF);
        // empty markers are neither queued nor dropped
        add(4'b0011, 8'h03, 64'h0000_0000_FFFF_FFFF, 0, 0, 0, 16'h00,  0, 0, 4'hF);
        // write and read together at count==1
        add(4'b0010, 8'h00, 64'h0000_0000_0055_0000, 0, 1, 0, 16'h55,  1, 0, 4'hF);
        add(4'b1000, 8'h80, 64'h0077_0000_0000_0000, 1, 1, 2, 16'h77,  1, 0, 4'hF);
        add(4'b0000, 8'h00, 64'h0,                   1, 0, 0, 16'h00,  0, 0, 4'hF);
        // admission threshold around free == RSV
        add(4'b1111, 8'hE4, 64'h0033_0032_0031_0030, 0, 1, 0, 16'h30,  4, 0, 4'hF);
        add(4'b1111, 8'hE4, 64'h0037_0036_0035_0034, 0, 1, 0, 16'h30,  8, 0, 4'h0);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 1, 16'h31,  7, 0, 4'hF);
        add(4'b1111, 8'hE4, 64'h003B_003A_0039_0038, 0, 1, 1, 16'h31, 11, 0, 4'h0);
        add(4'b0011, 8'hE4, 64'h0000_0000_003D_003C, 0, 1, 1, 16'h31, 13, 0, 4'h0);
        add(4'b0100, 8'hE4, 64'h0000_003E_0000_0000, 0, 1, 1, 16'h31, 14, 0, 4'h0);
        // overflow with rr=3: lanes 3 and 0 kept, 1 and 2 dropped
        add(4'b1111, 8'hE4, 64'h0043_0042_0041_0040, 0, 1, 1, 16'h31, 16, 1, 4'h0);
        // full plus read: everything dropped
        add(4'b1111, 8'hE4, 64'h0053_0052_0051_0050, 1, 1, 2, 16'h32, 15, 1, 4'h0);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 3, 16'h33, 14, 1, 4'h0);
        add(4'b0000, 8'h00, 64'h0,                   1, 1, 0, 16'h34, 13, 1, 4'h0);

        i_arst = 1'b1;
        i_is_level0_pop = '0;
        i_tree_id = '0;
        i_pop_data = '0;
        i_ready = 1'b0;
        #3;
        check_outputs("reset", 0, 0, 16'h0, 5'd0, 0, 4'hF);
        @(negedge i_clk);
        i_arst = 1'b0;
        @(posedge i_clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            i_is_level0_pop = vecs[i].pop;
            i_tree_id       = vecs[i].tids;
            i_pop_data      = vecs[i].data;
            i_ready         = vecs[i].ready;
            step();
            check_outputs($sformatf("v%0d", i), vecs[i].ev, vecs[i].eh.tree_id, vecs[i].eh.data,
                          vecs[i].ec, vecs[i].eo, vecs[i].ea);
        end

        // drain down to five entries, checking order through the wrap
        i_is_level0_pop = '0;
        i_pop_data = '0;
        i_tree_id = '0;
        i_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            step();
            check($sformatf("drain%0d data", j), 32'(o_data), 32'(drain_d[j]));
            check($sformatf("drain%0d tree", j), 32'(o_tree_id), 32'(drain_t[j]));
            check($sformatf("drain%0d count", j), 32'(o_count), 32'(12 - j));
        end
        check("drain allow", 32'(o_pop_allow), 32'hF);
`ifdef PIFO_EGRESS_STATS_EN
        check("stat empty", o_empty_pop_cnt, 32'd2);
        check("stat drop", o_drop_cnt, 32'd6);
        check("stat egress", o_egress_cnt, 32'd21);
`endif

        // asynchronous reset with five entries queued
        i_ready = 1'b0;
        #2;
        i_arst = 1'b1;
        #1;
        check_outputs("midrst", 0, 0, 16'h0, 5'd0, 0, 4'hF);
`ifdef PIFO_EGRESS_STATS_EN
        check("midrst drop", o_drop_cnt, 32'd0);
`endif
        @(negedge i_clk);
        i_arst = 1'b0;
        step();
        check_outputs("postrst idle", 0, 0, 16'h0, 5'd0, 0, 4'hF);
        i_is_level0_pop = 4'b0001;
        i_tree_id = 8'h02;
        i_pop_data = 64'h0000_0000_0000_0099;
        step();
        check_outputs("postrst cap", 1, 2, 16'h99, 5'd1, 0, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
